// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin arbiter in front of one shared 8-bit ALU.
// Two requesters hand over {opcode, a, b} with valid/ready. The winner's
// operands are latched and executed (multiply takes MUL_LAT cycles, all other
// ops take one cycle). The 15-bit result comes back on a valid/ready response
// channel, tagged with the id of the requester that issued it.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   reqN_valid/reqN_ready request handshake for requester N (ready is combinational)
//   reqN_s/reqN_a/reqN_b  opcode and operands for requester N
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_y         requester tag and 15-bit result
//   busy                  high whenever an operation is in flight or awaiting pickup
module alu_rr_sched #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_s,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_s,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [14:0] rsp_y,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [2:0] OP_MUL  = 3'b110;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_last;
    logic        r_id;
    logic [2:0]  r_s;
    logic [7:0]  r_a;
    logic [7:0]  r_b;

    logic        w_tie;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_acc;
    logic [2:0]  w_s;
    logic [7:0]  w_a_in;
    logic [7:0]  w_b_in;
    logic [14:0] w_a;
    logic [14:0] w_b;
    logic [14:0] w_y;

    // On a tie the requester that did not win last time gets the grant.
    // A lone requester is served without touching the fairness pointer.
    assign w_tie  = req0_valid & req1_valid;
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);
    assign w_gnt0 = req0_valid & ~w_gnt1;

    assign req0_ready = (r_state == IDLE) & w_gnt0;
    assign req1_ready = (r_state == IDLE) & w_gnt1;
    assign w_acc      = req0_ready | req1_ready;
    assign busy       = (r_state != IDLE);

    assign w_s    = w_gnt1 ? req1_s : req0_s;
    assign w_a_in = w_gnt1 ? req1_a : req0_a;
    assign w_b_in = w_gnt1 ? req1_b : req0_b;

    // Operands are zero-extended so every op wraps at 15 bits.
    assign w_a = {7'd0, r_a};
    assign w_b = {7'd0, r_b};

    always_comb begin
        w_y = '0;
        case (r_s)
            3'b000:  w_y = w_a + w_b;
            3'b001:  w_y = w_a - w_b;
            3'b010:  w_y = w_a & w_b;
            3'b011:  w_y = ~w_a;
            3'b100:  w_y = w_a | w_b;
            3'b101:  w_y = w_a ^ w_b;
            3'b110:  w_y = w_a * w_b;
            default: w_y = ~(w_a ^ w_b);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_id      <= 1'b0;
            r_s       <= '0;
            r_a       <= '0;
            r_b       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_state <= EXEC;
                        r_id    <= w_gnt1;
                        r_s     <= w_s;
                        r_a     <= w_a_in;
                        r_b     <= w_b_in;
                        r_cnt   <= (w_s == OP_MUL) ? MUL_CNT : 4'd0;
                        if (w_tie)
                            r_last <= w_gnt1;
                    end
                end
                EXEC: begin
                    if (r_cnt == 4'd0) begin
                        rsp_y     <= w_y;
                        rsp_id    <= r_id;
                        rsp_valid <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
